// File: rtl/status_unit_if.sv
// Instruction/status bundle between an issuing stage and the status unit.
// master drives the instruction and the direct write; slave returns the flags and result.
interface status_unit_if;
    logic        valid_in;
    logic        cond_pass;
    logic        s_bit;
    logic [3:0]  exe_cmd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        flush;
    logic        wr_en;
    logic [3:0]  wr_data;
    logic [3:0]  status;
    logic [3:0]  status_fwd;
    logic [31:0] result_q;
    logic        result_valid;

    modport master (
        output valid_in, cond_pass, s_bit, exe_cmd, op_a, op_b,
               stall, flush, wr_en, wr_data,
        input  status, status_fwd, result_q, result_valid
    );

    modport slave (
        input  valid_in, cond_pass, s_bit, exe_cmd, op_a, op_b,
               stall, flush, wr_en, wr_data,
        output status, status_fwd, result_q, result_valid
    );
endinterface

// File: rtl/status_unit.sv
// ALU result register plus NZCV status flags, with a direct status write and a forwarded next-status view.
// Latency: 1 cycle from an accepted instruction to result_q/status.
// Backpressure: stall freezes every register except a direct status write; flush squashes the current instruction.
module status_unit (
    input  logic           clk,
    input  logic           rst,
    status_unit_if.slave   bus
);
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [3:0]  status;
    logic [3:0]  status_next;
    logic [31:0] result_q;
    logic        result_valid;

    logic [31:0] r;
    logic [32:0] sum;
    logic        c_new;
    logic        v_new;
    logic        supported;
    logic        accept;
    logic        carry_in;

    assign carry_in = status[1];
    assign accept   = bus.valid_in & bus.cond_pass & ~bus.stall & ~bus.flush;

    always_comb begin
        r         = 32'd0;
        sum       = 33'd0;
        c_new     = status[1];
        v_new     = status[0];
        supported = 1'b1;
        case (bus.exe_cmd)
            CMD_MOV: r = bus.op_b;
            CMD_MVN: r = ~bus.op_b;
            CMD_ADD, CMD_ADC: begin
                sum   = {1'b0, bus.op_a} + {1'b0, bus.op_b}
                      + {32'd0, (bus.exe_cmd == CMD_ADC) & carry_in};
                r     = sum[31:0];
                c_new = sum[32];
                v_new = (bus.op_a[31] == bus.op_b[31]) & (r[31] != bus.op_a[31]);
            end
            // a - b - ~C == a + ~b + C, so carry out is the inverted borrow
            CMD_SUB, CMD_SBC: begin
                sum   = {1'b0, bus.op_a} + {1'b0, ~bus.op_b}
                      + {32'd0, (bus.exe_cmd == CMD_SUB) | carry_in};
                r     = sum[31:0];
                c_new = sum[32];
                v_new = (bus.op_a[31] != bus.op_b[31]) & (r[31] != bus.op_a[31]);
            end
            CMD_AND: r = bus.op_a & bus.op_b;
            CMD_ORR: r = bus.op_a | bus.op_b;
            CMD_EOR: r = bus.op_a ^ bus.op_b;
            default: supported = 1'b0;
        endcase
    end

    // Shared by the register and the forwarding port so the two cannot diverge
    always_comb begin
        status_next = status;
        if (rst)
            status_next = 4'b0000;
        else if (bus.wr_en)
            status_next = bus.wr_data;
        else if (accept && bus.s_bit && supported)
            status_next = {r[31], (r == 32'd0), c_new, v_new};
    end

    always_ff @(posedge clk) begin
        status <= status_next;
        if (rst) begin
            result_q     <= 32'd0;
            result_valid <= 1'b0;
        end else if (!bus.stall) begin
            if (accept) begin
                result_q     <= r;
                result_valid <= 1'b1;
            end else begin
                result_valid <= 1'b0;
            end
        end
    end

    assign bus.status       = status;
    assign bus.status_fwd   = status_next;
    assign bus.result_q     = result_q;
    assign bus.result_valid = result_valid;
endmodule

// File: tb/tb_status_unit.sv
// Directed-vector bench for status_unit with hand-computed expected flags and results.
module tb_status_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    status_unit_if bus ();

    status_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011,
                           SUB = 4'b0100, SBC = 4'b0101, AND = 4'b0110, ORR = 4'b0111,
                           EOR = 4'b1000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic cp, input logic s, input logic [3:0] cmd,
                         input logic [31:0] a, input logic [31:0] b);
        bus.valid_in  = v;
        bus.cond_pass = cp;
        bus.s_bit     = s;
        bus.exe_cmd   = cmd;
        bus.op_a      = a;
        bus.op_b      = b;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_data = 4'd0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, ADD, 32'd1, 32'd2);
        #1;
        n_cmp++; if (bus.status_fwd !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd got %b want 0000", bus.status_fwd); end
        step(); step();
        n_cmp++; if (bus.status !== 4'b0000) begin n_fail++; $display("FAIL reset_status got %b want 0000", bus.status); end
        n_cmp++; if (bus.result_q !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result_q); end
        n_cmp++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.result_valid); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 1'b1, 1'b1, ADD, 32'h7FFFFFFF, 32'd1);
        #1;
        n_cmp++; if (bus.status_fwd !== 4'b1001) begin n_fail++; $display("FAIL add_ovf_fwd got %b want 1001", bus.status_fwd); end
        step();
        n_cmp++; if (bus.result_q !== 32'h80000000) begin n_fail++; $display("FAIL add_ovf_result got %h want 80000000", bus.result_q); end
        n_cmp++; if (bus.status !== 4'b1001) begin n_fail++; $display("FAIL add_ovf_status got %b want 1001", bus.status); end
        n_cmp++; if (bus.result_valid !== 1'b1) begin n_fail++; $display("FAIL add_ovf_valid got %b want 1", bus.result_valid); end
    endtask

    task automatic test_sub_sbc();
        drive(1'b1, 1'b1, 1'b1, SUB, 32'd5, 32'd5);
        step();
        n_cmp++; if (bus.result_q !== 32'd0 || bus.status !== 4'b0110) begin n_fail++; $display("FAIL sub_eq got %h/%b want 0/0110", bus.result_q, bus.status); end
        drive(1'b1, 1'b1, 1'b1, SBC, 32'd5, 32'd5);
        step();
        n_cmp++; if (bus.result_q !== 32'd0 || bus.status !== 4'b0110) begin n_fail++; $display("FAIL sbc_eq got %h/%b want 0/0110", bus.result_q, bus.status); end
    endtask

    task automatic test_carry_chain();
        drive(1'b1, 1'b1, 1'b1, ADD, 32'hFFFFFFFF, 32'd1);
        step();
        n_cmp++; if (bus.result_q !== 32'd0 || bus.status !== 4'b0110) begin n_fail++; $display("FAIL add_carry got %h/%b want 0/0110", bus.result_q, bus.status); end
        drive(1'b1, 1'b1, 1'b0, ADC, 32'd0, 32'd0);
        step();
        n_cmp++; if (bus.result_q !== 32'd1 || bus.status !== 4'b0110) begin n_fail++; $display("FAIL adc_cin got %h/%b want 1/0110", bus.result_q, bus.status); end
    endtask

    task automatic test_squash();
        drive(1'b1, 1'b0, 1'b1, ADD, 32'd7, 32'd9);
        step();
        n_cmp++; if (bus.result_valid !== 1'b0 || bus.result_q !== 32'd1 || bus.status !== 4'b0110) begin
            n_fail++; $display("FAIL cond_fail got v=%b r=%h s=%b want 0/1/0110", bus.result_valid, bus.result_q, bus.status); end
        drive(1'b1, 1'b1, 1'b0, MOV, 32'd0, 32'h1234);
        step();
        n_cmp++; if (bus.result_valid !== 1'b1 || bus.result_q !== 32'h1234) begin n_fail++; $display("FAIL mov got v=%b r=%h want 1/1234", bus.result_valid, bus.result_q); end
        drive(1'b1, 1'b1, 1'b1, ADD, 32'd7, 32'd9);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.result_valid !== 1'b0 || bus.result_q !== 32'h1234 || bus.status !== 4'b0110) begin
            n_fail++; $display("FAIL flush got v=%b r=%h s=%b want 0/1234/0110", bus.result_valid, bus.result_q, bus.status); end
    endtask

    task automatic test_stall_write();
        drive(1'b1, 1'b1, 1'b0, MOV, 32'd0, 32'hABCD);
        step();
        drive(1'b1, 1'b1, 1'b1, ADD, 32'd1, 32'd2);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.status_fwd !== 4'b0110) begin n_fail++; $display("FAIL stall1_fwd got %b want 0110", bus.status_fwd); end
        step();
        n_cmp++; if (bus.result_q !== 32'hABCD || bus.result_valid !== 1'b1 || bus.status !== 4'b0110) begin
            n_fail++; $display("FAIL stall1 got r=%h v=%b s=%b want ABCD/1/0110", bus.result_q, bus.result_valid, bus.status); end
        bus.wr_en = 1'b1;
        bus.wr_data = 4'b1010;
        #1;
        n_cmp++; if (bus.status_fwd !== 4'b1010) begin n_fail++; $display("FAIL stall2_fwd got %b want 1010", bus.status_fwd); end
        step();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.status !== 4'b1010) begin n_fail++; $display("FAIL stall2_status got %b want 1010", bus.status); end
        step();
        n_cmp++; if (bus.result_q !== 32'hABCD || bus.result_valid !== 1'b1 || bus.status !== 4'b1010) begin
            n_fail++; $display("FAIL stall3 got r=%h v=%b s=%b want ABCD/1/1010", bus.result_q, bus.result_valid, bus.status); end
        bus.stall = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic test_logic_ops();
        logic [3:0]  cmd_t [6] = '{EOR, AND, ORR, MVN, 4'b0000, 4'b1111};
        logic [31:0] a_t   [6] = '{32'hF0F0F0F0, 32'h0000FF00, 32'h80000000, 32'd0, 32'd5, 32'd3};
        logic [31:0] b_t   [6] = '{32'hF0F0F0F0, 32'h00000F0F, 32'h00000001, 32'd0, 32'd5, 32'd3};
        logic [31:0] r_t   [6] = '{32'd0, 32'h00000F00, 32'h80000001, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [3:0]  s_t   [6] = '{4'b0110, 4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, cmd_t[i], a_t[i], b_t[i]);
            step();
            n_cmp++; if (bus.result_q !== r_t[i] || bus.status !== s_t[i] || bus.result_valid !== 1'b1) begin
                n_fail++; $display("FAIL logic_%0d got r=%h s=%b v=%b want %h/%b/1", i, bus.result_q, bus.status, bus.result_valid, r_t[i], s_t[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  cmd_t [3] = '{SUB, SBC, SUB};
        logic [31:0] a_t   [3] = '{32'd3, 32'd10, 32'h80000000};
        logic [31:0] b_t   [3] = '{32'd5, 32'd3, 32'd1};
        logic [31:0] r_t   [3] = '{32'hFFFFFFFE, 32'd6, 32'h7FFFFFFF};
        logic [3:0]  s_t   [3] = '{4'b1000, 4'b0010, 4'b0011};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, cmd_t[i], a_t[i], b_t[i]);
            step();
            n_cmp++; if (bus.result_q !== r_t[i] || bus.status !== s_t[i]) begin
                n_fail++; $display("FAIL b2b_%0d got r=%h s=%b want %h/%b", i, bus.result_q, bus.status, r_t[i], s_t[i]); end
        end
        drive(1'b0, 1'b1, 1'b1, ADD, 32'd1, 32'd1);
        step();
        n_cmp++; if (bus.result_valid !== 1'b0 || bus.result_q !== 32'h7FFFFFFF || bus.status !== 4'b0011) begin
            n_fail++; $display("FAIL no_valid got v=%b r=%h s=%b want 0/7FFFFFFF/0011", bus.result_valid, bus.result_q, bus.status); end
    endtask

    task automatic test_write_priority();
        drive(1'b1, 1'b1, 1'b1, ADD, 32'd1, 32'd1);
        bus.wr_en = 1'b1;
        bus.wr_data = 4'b0010;
        step();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.status !== 4'b0010 || bus.result_q !== 32'd2 || bus.result_valid !== 1'b1) begin
            n_fail++; $display("FAIL wr_prio got s=%b r=%h v=%b want 0010/2/1", bus.status, bus.result_q, bus.result_valid); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b1, ADD, 32'hFFFFFFFF, 32'd5);
        bus.wr_en = 1'b1;
        bus.wr_data = 4'b1111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.status !== 4'b0000 || bus.result_q !== 32'd0 || bus.result_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid got s=%b r=%h v=%b want 0000/0/0", bus.status, bus.result_q, bus.result_valid); end
        drive(1'b1, 1'b1, 1'b1, ADC, 32'd1, 32'd1);
        step();
        n_cmp++; if (bus.result_q !== 32'd2 || bus.status !== 4'b0000) begin
            n_fail++; $display("FAIL post_rst_adc got r=%h s=%b want 2/0000", bus.result_q, bus.status); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_add_overflow();
        test_sub_sbc();
        test_carry_chain();
        test_squash();
        test_stall_write();
        test_logic_ops();
        test_back_to_back();
        test_write_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
